line_mem_arbiter: RTL and testbench
===================================

Name: line_mem_arbiter

Overview:
- Sits between the instruction cache, the data cache and the 64-bit burst physical-memory port (pmem_*) that the top-level bench drives.
- Arbitrates whole-line requests from both caches and serialises each 256-bit line into or out of 4 consecutive 64-bit beats.
- Returns a one-cycle line response to the cache it served.

Parameters:
- LINE_WIDTH, 256, cache line width in bits
- BURST_WIDTH, 64, pmem beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH = 4
- OFFSET_BITS, 5, line-offset bits zeroed on pmem_address

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_line_read  in  1  icache line read request (level, held until i_line_resp)
- i_line_addr  in  32  icache line address
- i_line_rdata  out  LINE_WIDTH  line read data to icache
- i_line_resp  out  1  one-cycle completion pulse to icache
- d_line_read  in  1  dcache line read request
- d_line_write  in  1  dcache line write request (writeback)
- d_line_addr  in  32  dcache line address
- d_line_wdata  in  LINE_WIDTH  dcache writeback line
- d_line_rdata  out  LINE_WIDTH  line read data to dcache
- d_line_resp  out  1  one-cycle completion pulse to dcache
- pmem_read  out  1  burst read, held for the whole burst
- pmem_write  out  1  burst write, held for the whole burst
- pmem_address  out  32  line-aligned burst address
- pmem_wdata  out  BURST_WIDTH  current write beat
- pmem_rdata  in  BURST_WIDTH  current read beat
- pmem_resp  in  1  one pulse per beat accepted/returned

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high; the block leaves reset synchronously to clk.
- Reset values:
  - state=IDLE, beat counter=0, line buffer=0.
  - pmem_read/pmem_write/i_line_resp/d_line_resp = 0.
  - pmem_address=0, pmem_wdata=0.
- FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE grant, evaluated each cycle, in this priority:
  - d_line_write -> D_WR
  - else d_line_read -> D_RD
  - else i_line_read -> I_RD
  - No request: stay in IDLE.
  - d_line_read and d_line_write both high is illegal; write wins.
- Address latch: on grant, latch {addr[31:OFFSET_BITS], OFFSET_BITS'0} into pmem_address and clear the beat counter.
  - D_WR also latches d_line_wdata into the line buffer.
  - Address and data stay stable for the whole burst regardless of input changes.
- I_RD / D_RD:
  - pmem_read=1.
  - Each cycle with pmem_resp=1: buffer[beat*64 +: 64] <= pmem_rdata, beat++.
  - On the 4th resp (beat==3): go to DONE; pmem_read drops in DONE.
- D_WR:
  - pmem_write=1, pmem_wdata = buffer[beat*64 +: 64].
  - Each pmem_resp advances beat; 4th resp -> DONE.
- Beat order: beat 0 is bits [63:0], ascending.
- Beat spacing: beats may be non-consecutive; the counter advances only on pmem_resp.
- DONE (exactly 1 cycle):
  - Assert the granted client's *_line_resp=1; the other client's resp stays 0.
  - Next state IDLE.
  - No grant is evaluated in DONE; the served client deasserts its request in the following cycle.
- Read data:
  - i_line_rdata and d_line_rdata both drive the line buffer, valid from the DONE cycle until the next grant.
  - After a write burst the buffer holds the written line.
- Ignored inputs: pmem_resp in IDLE or DONE; requests arriving mid-burst wait (level-held) for IDLE.
- Latency: idle-memory line fill with back-to-back resp = 1 grant cycle + 4 beat cycles + 1 DONE cycle.
- Reset mid-burst: immediate return to IDLE, all strobes low, no resp pulse, partial line discarded.

Optional Feature:
- Macro: LINE_ARB_RR_EN.
- Defined: round-robin between icache and dcache. A 1-bit last-served flag (reset = icache) gives the other client priority when both request in IDLE. Within the dcache, write still beats read.
- Undefined: fixed dcache-over-icache priority as above; the flag does not exist.

Test Plan:
- Icache fill:
  - Stimulus: i_line_read @0x0000_1234, memory returns beats 0x11..,0x22..,0x33..,0x44.. back-to-back.
  - Response: pmem_address=0x0000_1220; pmem_read high exactly 4 resp cycles; i_line_resp one pulse; i_line_rdata = {0x44..,0x33..,0x22..,0x11..}; d_line_resp stays 0.
- Dcache writeback:
  - Stimulus: d_line_write @0x8000_00E0, wdata = 256'h0123...CDEF; resp with 2-cycle gaps between beats.
  - Response: pmem_wdata shows bits [63:0],[127:64],[191:128],[255:192] in order, each held until its resp; d_line_resp one pulse.
- Simultaneous requests (macro undefined):
  - Stimulus: i_line_read and d_line_read asserted in the same cycle.
  - Response: dcache burst first, then icache burst; no overlap; pmem strobes low in DONE.
- Simultaneous requests (LINE_ARB_RR_EN defined):
  - Stimulus: 3 back-to-back contended rounds, both caches re-requesting each round.
  - Response: service order D, I, D.
- Reset mid-burst:
  - Stimulus: rst asserted after 2 read beats.
  - Response: outputs go to reset values asynchronously; no line resp; a new request after reset completes normally with 4 fresh beats.
- Stray resp:
  - Stimulus: pmem_resp pulsed in IDLE.
  - Response: no state change, no line resp.

Source files
------------

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter
// Arbitrates whole-line requests from the instruction and data caches onto a
// single burst physical-memory port. Each line is moved as BEATS consecutive
// BURST_WIDTH beats, lowest beat first, and the served cache receives a
// single-cycle line response.
//
// Optional build macro: LINE_ARB_RR_EN
//   defined   - round-robin between icache and dcache, tracked by a last-served
//               flag that resets to icache; dcache write still beats dcache read.
//   undefined - fixed priority: dcache write, then dcache read, then icache read.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no burst in flight, grant evaluated every cycle
// I_RD  | burst read filling the line buffer for the icache
// D_RD  | burst read filling the line buffer for the dcache
// D_WR  | burst write draining the line buffer (dcache writeback)
// DONE  | one cycle: line response to the served cache, no grant

module line_mem_arbiter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int OFFSET_BITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   i_line_read,
    input  logic [31:0]            i_line_addr,
    output logic [LINE_WIDTH-1:0]  i_line_rdata,
    output logic                   i_line_resp,

    input  logic                   d_line_read,
    input  logic                   d_line_write,
    input  logic [31:0]            d_line_addr,
    input  logic [LINE_WIDTH-1:0]  d_line_wdata,
    output logic [LINE_WIDTH-1:0]  d_line_rdata,
    output logic                   d_line_resp,

    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [31:0]            pmem_address,
    output logic [BURST_WIDTH-1:0] pmem_wdata,
    input  logic [BURST_WIDTH-1:0] pmem_rdata,
    input  logic                   pmem_resp
);

    localparam int BEATS     = LINE_WIDTH / BURST_WIDTH;
    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SLICE_LSB = $clog2(BURST_WIDTH);
    localparam int POS_BITS  = BEAT_BITS + SLICE_LSB;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_BITS-1:0]    beat_q, beat_d;
    logic [LINE_WIDTH-1:0]   buf_q, buf_d;
    logic [31:0]             addr_q, addr_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic                    iresp_q, iresp_d;
    logic                    dresp_q, dresp_d;
    // 1 when the burst in flight (or just finished) belongs to the dcache
    logic                    client_d_q, client_d_d;
`ifdef LINE_ARB_RR_EN
    // 1 when the most recently completed line went to the dcache
    logic                    last_dcache_q, last_dcache_d;
`endif

    logic                    d_any;
    logic                    pick_d;
    logic [POS_BITS-1:0]     beat_pos;
    logic [31:0]             i_aligned;
    logic [31:0]             d_aligned;
    logic                    unused_offset_bits;

    // Line offsets never reach the memory port.
    assign i_aligned = {i_line_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign d_aligned = {d_line_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign unused_offset_bits = ^{i_line_addr[OFFSET_BITS-1:0], d_line_addr[OFFSET_BITS-1:0]};

    assign d_any    = d_line_read | d_line_write;
    assign beat_pos = {beat_q, {SLICE_LSB{1'b0}}};

`ifdef LINE_ARB_RR_EN
    // Under contention the client that was not served last goes first.
    assign pick_d = d_any & (~i_line_read | ~last_dcache_q);
`else
    // The dcache always wins over the icache.
    assign pick_d = d_any;
`endif

    // Next-state, buffer and strobe decode for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        iresp_d    = 1'b0;
        dresp_d    = 1'b0;
        client_d_d = client_d_q;
`ifdef LINE_ARB_RR_EN
        last_dcache_d = last_dcache_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d && d_line_write) begin
                    state_d    = D_WR;
                    wr_d       = 1'b1;
                    addr_d     = d_aligned;
                    beat_d     = '0;
                    buf_d      = d_line_wdata;
                    client_d_d = 1'b1;
                end else if (pick_d) begin
                    state_d    = D_RD;
                    rd_d       = 1'b1;
                    addr_d     = d_aligned;
                    beat_d     = '0;
                    client_d_d = 1'b1;
                end else if (i_line_read) begin
                    state_d    = I_RD;
                    rd_d       = 1'b1;
                    addr_d     = i_aligned;
                    beat_d     = '0;
                    client_d_d = 1'b0;
                end
            end
            I_RD, D_RD: begin
                if (pmem_resp) begin
                    buf_d[beat_pos +: BURST_WIDTH] = pmem_rdata;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        rd_d    = 1'b0;
                        iresp_d = ~client_d_q;
                        dresp_d = client_d_q;
                    end
                end
            end
            D_WR: begin
                if (pmem_resp) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        wr_d    = 1'b0;
                        dresp_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef LINE_ARB_RR_EN
                last_dcache_d = client_d_q;
`endif
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            buf_q      <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            iresp_q    <= 1'b0;
            dresp_q    <= 1'b0;
            client_d_q <= 1'b0;
`ifdef LINE_ARB_RR_EN
            last_dcache_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            buf_q      <= buf_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            iresp_q    <= iresp_d;
            dresp_q    <= dresp_d;
            client_d_q <= client_d_d;
`ifdef LINE_ARB_RR_EN
            last_dcache_q <= last_dcache_d;
`endif
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wr_q ? buf_q[beat_pos +: BURST_WIDTH] : '0;
    assign i_line_resp  = iresp_q;
    assign d_line_resp  = dresp_q;
    assign i_line_rdata = buf_q;
    assign d_line_rdata = buf_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Bench for line_mem_arbiter: acts as both caches and the burst memory.
// Expected lines are built from the beats the bench itself supplies, and the
// expected grant order comes from the priority rule (round-robin when
// LINE_ARB_RR_EN is defined).

module tb_line_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_line_read;
    logic [31:0]  i_line_addr;
    logic [255:0] i_line_rdata;
    logic         i_line_resp;
    logic         d_line_read;
    logic         d_line_write;
    logic [31:0]  d_line_addr;
    logic [255:0] d_line_wdata;
    logic [255:0] d_line_rdata;
    logic         d_line_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    int n_cmp = 0;
    int n_err = 0;
    bit model_last_d = 1'b0;

    line_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_line_read(i_line_read), .i_line_addr(i_line_addr),
        .i_line_rdata(i_line_rdata), .i_line_resp(i_line_resp),
        .d_line_read(d_line_read), .d_line_write(d_line_write),
        .d_line_addr(d_line_addr), .d_line_wdata(d_line_wdata),
        .d_line_rdata(d_line_rdata), .d_line_resp(d_line_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Which client the arbiter must pick when it sees these requests.
    function automatic bit model_pick_d(bit ireq, bit dreq, bit last_d);
        if (!dreq) return 1'b0;
        if (!ireq) return 1'b1;
`ifdef LINE_ARB_RR_EN
        return !last_d;
`else
        return 1'b1;
`endif
    endfunction

    // Caller has set the request on a falling edge; this plays memory for one
    // burst and checks strobes, address, beats, response and returned line.
    task automatic serve_burst(input string tag, input bit is_write, input bit to_d,
                               input logic [31:0] raw_addr, input logic [255:0] line,
                               input int gap);
        logic [31:0] exp_addr;
        int t;
        exp_addr = {raw_addr[31:5], 5'b0};
        t = 0;
        while (!(pmem_read || pmem_write) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!(pmem_read || pmem_write)) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_start: observed no strobe after %0d cycles, expected a burst", tag, t);
            return;
        end
        check($sformatf("%s_grant_lat", tag), t, 1);
        check($sformatf("%s_rd", tag), pmem_read, !is_write);
        check($sformatf("%s_wr", tag), pmem_write, is_write);
        check($sformatf("%s_addr", tag), pmem_address, exp_addr);
        if (to_d) begin
            d_line_addr  = $urandom;
            d_line_wdata = rand_line();
        end else begin
            i_line_addr = $urandom;
        end
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                pmem_resp  = 1'b0;
                pmem_rdata = {$urandom, $urandom};
                @(negedge clk);
                check($sformatf("%s_hold%0d", tag, b), is_write ? pmem_write : pmem_read, 1);
            end
            if (is_write) check($sformatf("%s_wbeat%0d", tag, b), pmem_wdata, line[b*64 +: 64]);
            check($sformatf("%s_addr_hold%0d", tag, b), pmem_address, exp_addr);
            pmem_rdata = is_write ? {$urandom, $urandom} : line[b*64 +: 64];
            pmem_resp  = 1'b1;
            @(negedge clk);
            pmem_resp  = 1'b0;
        end
        check($sformatf("%s_done_rd", tag), pmem_read, 0);
        check($sformatf("%s_done_wr", tag), pmem_write, 0);
        check($sformatf("%s_iresp", tag), i_line_resp, !to_d);
        check($sformatf("%s_dresp", tag), d_line_resp, to_d);
        check($sformatf("%s_irdata", tag), i_line_rdata, line);
        check($sformatf("%s_drdata", tag), d_line_rdata, line);
        model_last_d = to_d;
        if (to_d) begin
            d_line_read  = 1'b0;
            d_line_write = 1'b0;
        end else begin
            i_line_read = 1'b0;
        end
        @(negedge clk);
        check($sformatf("%s_iresp_end", tag), i_line_resp, 0);
        check($sformatf("%s_dresp_end", tag), d_line_resp, 0);
    endtask

    initial begin
        logic [255:0] line;
        logic [255:0] wline;
        int need_i;
        int need_d;
        bit win_d;

        rst          = 1'b1;
        i_line_read  = 1'b0;
        i_line_addr  = '0;
        d_line_read  = 1'b0;
        d_line_write = 1'b0;
        d_line_addr  = '0;
        d_line_wdata = '0;
        pmem_rdata   = '0;
        pmem_resp    = 1'b0;
        #1;
        check("rst_rd", pmem_read, 0);
        check("rst_wr", pmem_write, 0);
        check("rst_addr", pmem_address, 0);
        check("rst_wdata", pmem_wdata, 0);
        check("rst_iresp", i_line_resp, 0);
        check("rst_dresp", d_line_resp, 0);
        check("rst_buf", i_line_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Icache fill with the recognisable beat pattern.
        line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        i_line_addr = 32'h0000_1234;
        i_line_read = 1'b1;
        serve_burst("ifill", 1'b0, 1'b0, 32'h0000_1234, line, 0);

        // Dcache writeback with two idle cycles before every beat.
        wline = 256'h3210765498FEDCBA_2301674589EFCDAB_1032547698BADCFE_0123456789ABCDEF;
        d_line_addr  = 32'h8000_00E0;
        d_line_wdata = wline;
        d_line_write = 1'b1;
        serve_burst("dwb", 1'b1, 1'b1, 32'h8000_00E0, wline, 2);

        // Read and write together: the write must be chosen.
        wline = rand_line();
        d_line_addr  = $urandom;
        d_line_wdata = wline;
        d_line_read  = 1'b1;
        d_line_write = 1'b1;
        serve_burst("rw_both", 1'b1, 1'b1, d_line_addr, wline, 1);

        // Stray memory responses while idle change nothing.
        for (int k = 0; k < 3; k++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            @(negedge clk);
            pmem_resp  = 1'b0;
            check("stray_rd", pmem_read, 0);
            check("stray_wr", pmem_write, 0);
            check("stray_iresp", i_line_resp, 0);
            check("stray_dresp", d_line_resp, 0);
            check("stray_buf", d_line_rdata, wline);
        end

        // Contended reads: both caches request together, served client
        // drops its request for one cycle and comes back.
        i_line_addr = $urandom;
        d_line_addr = i_line_addr ^ 32'h8000_0000;
        i_line_read = 1'b1;
        d_line_read = 1'b1;
        need_i = 2;
        need_d = 2;
        while (need_i + need_d > 0) begin
            win_d = model_pick_d(i_line_read, d_line_read, model_last_d);
            line  = rand_line();
            serve_burst(win_d ? "cont_d" : "cont_i", 1'b0, win_d,
                        win_d ? d_line_addr : i_line_addr, line, $urandom_range(0, 2));
            if (win_d) begin
                need_d--;
                if (need_d > 0) d_line_read = 1'b1;
            end else begin
                need_i--;
                if (need_i > 0) i_line_read = 1'b1;
            end
        end

        // Reset in the middle of a read burst.
        i_line_addr = $urandom;
        i_line_read = 1'b1;
        @(negedge clk);
        check("mid_rd_up", pmem_read, 1);
        for (int b = 0; b < 2; b++) begin
            pmem_rdata = {$urandom, $urandom};
            pmem_resp  = 1'b1;
            @(negedge clk);
            pmem_resp  = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_rd", pmem_read, 0);
        check("mid_rst_addr", pmem_address, 0);
        check("mid_rst_iresp", i_line_resp, 0);
        check("mid_rst_buf", i_line_rdata, 0);
        model_last_d = 1'b0;
        i_line_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_iresp", i_line_resp, 0);
        check("post_rst_rd", pmem_read, 0);
        line = rand_line();
        i_line_addr = $urandom;
        i_line_read = 1'b1;
        serve_burst("post_rst", 1'b0, 1'b0, i_line_addr, line, 0);

        // Random single-client traffic.
        for (int n = 0; n < 8; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            line = rand_line();
            if (kind == 0) begin
                i_line_addr = $urandom;
                i_line_read = 1'b1;
                serve_burst("rnd_i", 1'b0, 1'b0, i_line_addr, line, $urandom_range(0, 3));
            end else if (kind == 1) begin
                d_line_addr = $urandom;
                d_line_read = 1'b1;
                serve_burst("rnd_dr", 1'b0, 1'b1, d_line_addr, line, $urandom_range(0, 3));
            end else begin
                d_line_addr  = $urandom;
                d_line_wdata = line;
                d_line_write = 1'b1;
                serve_burst("rnd_dw", 1'b1, 1'b1, d_line_addr, line, $urandom_range(0, 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
